// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_e;

  localparam int CNT_W                   = 16;
  localparam int DEF_RESET_CYCLES        = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 64;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 4096;
  localparam int DEF_MAX_RETRIES         = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by sync reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: resets the PLL, waits for stable lock, then releases sys_rst.
// Define PLL_SEQ_LOSS_CNT_EN to add the saturating lock-loss counter output loss_cnt.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES        = DEF_RESET_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
`ifdef PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that saw lock_s is the first of the consecutive stable
  // cycles, so STABLE itself only needs LOCK_STABLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] STB_LAST = (LOCK_STABLE_CYCLES >= 2) ?
                                          CNT_W'(LOCK_STABLE_CYCLES - 2) : '0;
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      RST_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + 4'd1;
          cnt_d   = '0;
          state_d = (retry_q + 4'd1 == RETRY_MAX) ? FAULT : RST_PLL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= STB_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = RST_PLL;
          cnt_d   = '0;
        end
      end
      FAULT: ;
      default: begin
        state_d = RST_PLL;
        cnt_d   = '0;
      end
    endcase
    // A relock request overrides whatever the state logic decided, including a timeout.
    if (relock_req) begin
      state_d = RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= RST_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_reset <= (state_d == RST_PLL) || (state_d == FAULT);
      sys_rst   <= (state_d != RUN);
      ready     <= (state_d == RUN);
      fault     <= (state_d == FAULT);
    end
  end

  assign retry_cnt = retry_q;
  assign state_o   = state_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic loss_hit;
  assign loss_hit = (state_q == RUN) && !lock_s && !relock_req;

  always_ff @(posedge clkin) begin
    if (reset)                           loss_cnt <= '0;
    else if (loss_hit && loss_cnt != '1) loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with a queue-based scoreboard of expected values.
module tb_pll_reset_seq;
  import pll_seq_pkg::*;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset, sys_rst, ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #10 clkin = ~clkin;

  pll_reset_seq dut (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt   (loss_cnt)
`endif
  );

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%0d", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] cur(input int sel);
    case (sel)
      0:       return 32'(state_o);
      1:       return 32'(ready);
      2:       return 32'(sys_rst);
      3:       return 32'(pll_reset);
      default: return 32'(retry_cnt);
    endcase
  endfunction

  // Ticks until the selected output equals val; n is the tick count (== bound on timeout).
  task automatic wait_for(input int sel, input logic [31:0] val, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cur(sel) !== val && n < bound);
  endtask

  initial begin
    int n;
    bit saw_wait;

    // Reset state
    repeat (3) tick();
    push("rst_state", 32'(RST_PLL));  pop_chk(32'(state_o));
    push("rst_pll_reset", 1);         pop_chk(32'(pll_reset));
    push("rst_sys_rst", 1);           pop_chk(32'(sys_rst));
    push("rst_ready", 0);             pop_chk(32'(ready));
    push("rst_fault", 0);             pop_chk(32'(fault));
    push("rst_retry", 0);             pop_chk(32'(retry_cnt));

    // Release: pll_reset held 16 cycles, lock 20 cycles later, release 2+64 after lock
    reset = 1'b0;
    push("pll_reset_len", 16);
    wait_for(3, 0, 100, n);           pop_chk(32'(n));
    repeat (20) tick();
    pll_lock = 1'b1;
    push("sys_rst_fall_after_lock", 66);
    push("ready_with_sys_rst_fall", 1);
    push("run_state", 32'(RUN));
    wait_for(2, 0, 200, n);           pop_chk(32'(n));
    pop_chk(32'(ready));
    pop_chk(32'(state_o));

    // Lock drop and relock_req in the same RUN cycle
    pll_lock = 1'b0;
    repeat (2) tick();
    push("run_before_sync_latency", 32'(RUN));
    pop_chk(32'(state_o));
    relock_req = 1'b1;
    push("relock_state", 32'(RST_PLL));
    push("relock_sys_rst", 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    push("relock_loss_cnt", 0);
`endif
    tick();
    relock_req = 1'b0;
    pop_chk(32'(state_o));
    pop_chk(32'(sys_rst));
`ifdef PLL_SEQ_LOSS_CNT_EN
    pop_chk(32'(loss_cnt));
`endif

    // Glitch at STABLE cycle 30 returns to WAIT_LOCK without a retry
    push("relock_rst_len", 16);
    wait_for(0, 32'(WAIT_LOCK), 100, n); pop_chk(32'(n));
    pll_lock = 1'b1;
    push("stable_entry_latency", 3);
    wait_for(0, 32'(STABLE), 10, n);  pop_chk(32'(n));
    repeat (29) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    push("ready_after_glitch", 66);
    push("glitch_saw_wait_lock", 1);
    push("glitch_retry", 0);
    n = 0;
    saw_wait = 1'b0;
    do begin
      tick();
      n++;
      if (state_o === WAIT_LOCK) saw_wait = 1'b1;
    end while (ready !== 1'b1 && n < 200);
    pop_chk(32'(n));
    pop_chk(32'(saw_wait));
    pop_chk(32'(retry_cnt));

    // Lock loss in RUN
    pll_lock = 1'b0;
    push("loss_sys_rst_latency", 3);
    push("loss_pll_reset", 1);
    push("loss_state", 32'(RST_PLL));
`ifdef PLL_SEQ_LOSS_CNT_EN
    push("loss_cnt_first", 1);
`endif
    wait_for(2, 1, 10, n);            pop_chk(32'(n));
    pop_chk(32'(pll_reset));
    pop_chk(32'(state_o));
`ifdef PLL_SEQ_LOSS_CNT_EN
    pop_chk(32'(loss_cnt));
`endif

    // Three timeouts with lock held low -> FAULT
    for (int i = 0; i < 3; i++) begin
      push($sformatf("timeout%0d_wait_entry", i), 32'(WAIT_LOCK));
      wait_for(0, 32'(WAIT_LOCK), 100, n); pop_chk(32'(state_o));
      push($sformatf("timeout%0d_len", i), 4096);
      push($sformatf("timeout%0d_retry", i), 32'(i + 1));
      push($sformatf("timeout%0d_next", i), (i < 2) ? 32'(RST_PLL) : 32'(FAULT));
      wait_for(4, 32'(i + 1), 5000, n);
      pop_chk(32'(n));
      pop_chk(32'(retry_cnt));
      pop_chk(32'(state_o));
    end
    repeat (5) tick();
    push("fault_flag", 1);            pop_chk(32'(fault));
    push("fault_pll_reset", 1);       pop_chk(32'(pll_reset));
    push("fault_hold_state", 32'(FAULT)); pop_chk(32'(state_o));
    relock_req = 1'b1;
    push("fault_relock_state", 32'(RST_PLL));
    push("fault_relock_retry", 0);
    push("fault_relock_fault", 0);
    tick();
    relock_req = 1'b0;
    pop_chk(32'(state_o));
    pop_chk(32'(retry_cnt));
    pop_chk(32'(fault));

    // Reset (with a coincident relock_req) while in STABLE
    pll_lock = 1'b1;
    push("reach_stable", 32'(STABLE));
    wait_for(0, 32'(STABLE), 100, n); pop_chk(32'(state_o));
    repeat (5) tick();
    reset = 1'b1;
    relock_req = 1'b1;
    push("midrst_state", 32'(RST_PLL));
    push("midrst_pll_reset", 1);
    push("midrst_sys_rst", 1);
    push("midrst_ready", 0);
    push("midrst_fault", 0);
    push("midrst_retry", 0);
    tick();
    pop_chk(32'(state_o));
    pop_chk(32'(pll_reset));
    pop_chk(32'(sys_rst));
    pop_chk(32'(ready));
    pop_chk(32'(fault));
    pop_chk(32'(retry_cnt));
`ifdef PLL_SEQ_LOSS_CNT_EN
    push("midrst_loss_cnt", 0);       pop_chk(32'(loss_cnt));
`endif
    reset = 1'b0;
    relock_req = 1'b0;
    push("restart_pll_reset_len", 16);
    wait_for(3, 0, 100, n);           pop_chk(32'(n));
    // lock already stable: 1 WAIT_LOCK cycle + 63 STABLE cycles
    push("restart_ready_len", 64);
    wait_for(1, 1, 200, n);           pop_chk(32'(n));

`ifdef PLL_SEQ_LOSS_CNT_EN
    // Saturation after 256 lock losses
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b0;
      wait_for(2, 1, 10, n);
      if (i == 0) begin
        push("loss_cnt_after_one", 1);  pop_chk(32'(loss_cnt));
      end
      if (i == 254) begin
        push("loss_cnt_255", 255);      pop_chk(32'(loss_cnt));
      end
      pll_lock = 1'b1;
      wait_for(1, 1, 200, n);
      if (n >= 200) begin
        push("loss_loop_ready_timeout", 0); pop_chk(32'(n));
      end
    end
    push("loss_cnt_saturated", 255);  pop_chk(32'(loss_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter RESET_CYCLES, default 16: number of cycles pll_reset is held per PLL reset attempt; legal range 1..255.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 64: number of consecutive synchronized-lock cycles required before release; legal range 1..65535.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 4096: maximum number of cycles spent waiting for lock per attempt; legal range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: number of timed-out attempts before the block enters FAULT; legal range 1..15.
REQ-005 clkin  in  1  free-running 50 MHz reference clock; the same clock that feeds the PLL input.
REQ-006 reset  in  1  one clock; reset is synchronous and active-high.
REQ-007 pll_lock  in  1  PLL lock output; asynchronous to clkin.
REQ-008 relock_req  in  1  single-cycle pulse requesting a fresh PLL reset sequence.
REQ-009 pll_reset  out  1  drives the PLL reset input; active-high.
REQ-010 sys_rst  out  1  reset for logic in the PLL output domains; active-high.
REQ-011 ready  out  1  high while in RUN.
REQ-012 fault  out  1  high while in FAULT.
REQ-013 retry_cnt  out  4  count of timed-out attempts in the current sequence.
REQ-014 state_o  out  3  current state encoding, for debug.
REQ-015 loss_cnt  out  8  count of lock-loss events; present only when the macro in REQ-030 is defined.

Function
REQ-016 pll_lock SHALL pass through a two-flop synchronizer producing lock_s, giving 2 cycles of latency; all decisions SHALL use lock_s only.
REQ-017 The state machine SHALL have five states: RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT; all outputs SHALL be registered.
REQ-018 RST_PLL: pll_reset=1 and sys_rst=1 for exactly RESET_CYCLES cycles, then the block SHALL move to WAIT_LOCK with the cycle counter cleared.
REQ-019 WAIT_LOCK: pll_reset=0 and sys_rst=1; lock_s=1 SHALL move the block to STABLE with the counter cleared; LOCK_TIMEOUT_CYCLES cycles without lock SHALL be treated as a timeout.
REQ-020 On a timeout the block SHALL increment retry_cnt; if the new value equals MAX_RETRIES it SHALL go to FAULT, otherwise to RST_PLL.
REQ-021 STABLE: the counter SHALL increment while lock_s=1; lock_s=0 SHALL return the block to WAIT_LOCK with the counter cleared and SHALL NOT count as a retry; reaching LOCK_STABLE_CYCLES SHALL move the block to RUN.
REQ-022 RUN: sys_rst=0 and ready=1 on the first RUN cycle; retry_cnt SHALL be cleared on entry to RUN; lock_s=0 SHALL move the block to RST_PLL, with sys_rst reasserting on the next cycle.
REQ-023 FAULT: pll_reset=1, sys_rst=1, fault=1; the block SHALL leave FAULT only on reset or relock_req.
REQ-024 relock_req in any state SHALL move the block to RST_PLL and clear retry_cnt and the cycle counter; if it coincides with a timeout, relock_req wins and the retry is not counted.
REQ-025 In RUN, if lock loss and relock_req occur in the same cycle, the block SHALL go to RST_PLL and SHALL NOT increment loss_cnt.
REQ-026 The counter SHALL be 16 bits wide, SHALL be cleared on every state change, and SHALL never wrap within a state.

Reset
REQ-027 reset=1 at a clkin edge SHALL force: state RST_PLL, counter 0, pll_reset=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, synchronizer flops 0.
REQ-028 When reset is asserted mid-sequence, including in RUN or FAULT, the block SHALL restart the full sequence after reset deasserts.
REQ-029 reset SHALL take priority over relock_req and over every other input.

Configuration
REQ-030 With PLL_SEQ_LOSS_CNT_EN defined: loss_cnt SHALL be an 8-bit saturating counter that increments on each RUN-to-RST_PLL transition caused by lock loss; it SHALL hold at 255 and be cleared only by reset.
REQ-031 Without PLL_SEQ_LOSS_CNT_EN: the loss_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 Package pll_seq_pkg SHALL hold the state enum (3 bits), default parameter constants, and the counter width constant.
REQ-033 The synchronizer SHALL be a sub-module named sync_2ff (1-bit, reset to 0); all other logic SHALL be inline.

Verification
REQ-034 Reset release, lock high 20 cycles after pll_reset falls -> pll_reset high for exactly 16 cycles; ready rises 2+64 cycles after lock rises; sys_rst falls on the same cycle.
REQ-035 Lock held low -> three 4096-cycle timeouts with retry_cnt stepping 1, 2, 3 -> fault=1, pll_reset=1; a relock_req pulse then gives retry_cnt=0 and state RST_PLL.
REQ-036 Lock glitch low for 1 cycle at cycle 30 of STABLE -> return to WAIT_LOCK with retry_cnt unchanged; RUN is reached 64 stable cycles after the glitch ends.
REQ-037 Lock drop in RUN -> sys_rst=1 and pll_reset=1 on the next cycles; loss_cnt=1 with the macro defined; after 256 losses loss_cnt=255.
REQ-038 Lock drop and relock_req in the same RUN cycle -> RST_PLL with loss_cnt unchanged; reset asserted while in STABLE -> all outputs at their REQ-027 values on the next edge.
